// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Sequencing and arbitration front-end for the single-port instruction
// memory. One memory port is shared between the CPU fetch path and the
// program loader. After reset the block sits in BOOT, where only the loader
// may touch the memory, so the program image can be written. Once
// boot_done_i is seen the block moves to RUN for good (until reset), and
// fetch and loader compete for the port.
//
// The memory behind this block is registered with one cycle of read latency.
// This block remembers which port owns the read that was granted, and returns
// the data on that port's rvalid/rdata in the following cycle.
//
// Build option:
//   IMEM_ARB_RR_EN  defined   -> round-robin arbitration in RUN. On
//                                 contention the port that did not win the
//                                 last contested grant wins.
//                   undefined -> fixed priority. Fetch always beats the
//                                 loader in RUN, so the loader can starve.
//
// Parameters:
//   DEPTH        number of 32-bit words in the instruction memory
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous, active-low reset
//   f_req_i      fetch read request
//   f_addr_i     fetch byte address
//   f_gnt_o      fetch request accepted this cycle (combinational)
//   f_rvalid_o   fetch read data valid
//   f_rdata_o    fetch read data (0 when not valid)
//   l_req_i      loader request
//   l_we_i       loader write (1) / read (0)
//   l_addr_i     loader byte address
//   l_wdata_i    loader write data
//   l_gnt_o      loader request accepted this cycle (combinational)
//   l_rvalid_o   loader read data valid
//   l_rdata_o    loader read data (0 when not valid)
//   boot_done_i  loader has finished writing the image
//   running_o    high in RUN
//   err_o        sticky: an out-of-range access was granted
//   mem_en_o     memory access strobe
//   mem_we_o     memory write enable
//   mem_addr_o   memory byte address, word aligned
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid one cycle after mem_en_o
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int unsigned DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,

    input  logic        l_req_i,
    input  logic        l_we_i,
    input  logic [31:0] l_addr_i,
    input  logic [31:0] l_wdata_i,
    output logic        l_gnt_o,
    output logic        l_rvalid_o,
    output logic [31:0] l_rdata_o,

    input  logic        boot_done_i,
    output logic        running_o,
    output logic        err_o,

    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

    state_t      state;
    logic        fetch_pref;
    logic        rd_zero;
    logic        f_gnt;
    logic        l_gnt;
    logic        any_gnt;
    logic        contested;
    logic        in_range;
    logic [31:0] sel_addr;
    logic        unused_addr_bits;

    // Round-robin keeps a pointer that says which port wins the next
    // contested cycle. In fixed-priority builds fetch is always preferred.
`ifdef IMEM_ARB_RR_EN
    logic fetch_pref_q;
    assign fetch_pref = fetch_pref_q;
`else
    assign fetch_pref = 1'b1;
`endif

    // Grant decision. The grants depend only on the current requests, the
    // state and the priority pointer, so a request is accepted in the same
    // cycle it is raised. No grant is issued while reset is held, so the
    // memory stays idle during reset.
    always_comb begin
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        contested = 1'b0;
        if (rst_i) begin
            if (state == BOOT) begin
                l_gnt = l_req_i;
            end else begin
                contested = f_req_i && l_req_i;
                if (contested) begin
                    f_gnt = fetch_pref;
                    l_gnt = !fetch_pref;
                end else begin
                    f_gnt = f_req_i;
                    l_gnt = l_req_i;
                end
            end
        end
    end

    assign f_gnt_o = f_gnt;
    assign l_gnt_o = l_gnt;
    assign any_gnt = f_gnt || l_gnt;

    // The address of the winning port drives the memory. An out-of-range
    // word index is still granted, so the requester does not stall, but the
    // memory strobe is withheld. A write is then dropped and a read
    // returns zero.
    assign sel_addr = f_gnt ? f_addr_i : l_addr_i;
    assign in_range = sel_addr[31:2] < DEPTH_IDX;

    assign mem_en_o    = any_gnt && in_range;
    assign mem_we_o    = mem_en_o && l_gnt && l_we_i;
    assign mem_addr_o  = {sel_addr[31:2], 2'b00};
    assign mem_wdata_o = l_wdata_i;

    // The byte-offset bits are deliberately ignored; the memory is word
    // addressed.
    assign unused_addr_bits = &{1'b0, sel_addr[1:0]};

    // State machine and registered outputs. The read owner is recorded as
    // the rvalid flags themselves. Fetch accesses are always reads, and a
    // loader access is a read only when l_we_i is low. rd_zero remembers
    // that the granted read was out of range, so its data is forced to 0.
    // Reset clears the owner flags, which cancels a read still in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= BOOT;
            running_o    <= 1'b0;
            err_o        <= 1'b0;
            f_rvalid_o   <= 1'b0;
            l_rvalid_o   <= 1'b0;
            rd_zero      <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            fetch_pref_q <= 1'b1;
`endif
        end else begin
            if ((state == BOOT) && boot_done_i) begin
                state     <= RUN;
                running_o <= 1'b1;
            end
            if (any_gnt && !in_range) begin
                err_o <= 1'b1;
            end
            f_rvalid_o <= f_gnt;
            l_rvalid_o <= l_gnt && !l_we_i;
            rd_zero    <= !in_range;
`ifdef IMEM_ARB_RR_EN
            // Only a contested grant moves the pointer. The next contested
            // cycle goes to the port that lost this one.
            if (contested) begin
                fetch_pref_q <= l_gnt;
            end
`endif
        end
    end

    // Read data is steered from the memory straight to the owning port. The
    // other port sees zero.
    assign f_rdata_o = (f_rvalid_o && !rd_zero) ? mem_rdata_i : 32'h0;
    assign l_rdata_o = (l_rvalid_o && !rd_zero) ? mem_rdata_i : 32'h0;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencing and arbitration front-end for the single-port instruction memory. Shares one memory port between the CPU fetch path and the program loader, enforcing a boot phase in which only the loader may write the program image. Sits between Program_Counter/fetch logic and a registered, one-cycle-latency instruction memory array.

## Interface
- DEPTH, 32, number of 32-bit words in the instruction memory
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-low reset
- f_req_i  input  1  fetch read request
- f_addr_i  input  32  fetch byte address
- f_gnt_o  output  1  fetch request accepted this cycle
- f_rvalid_o  output  1  fetch read data valid
- f_rdata_o  output  32  fetch read data
- l_req_i  input  1  loader request
- l_we_i  input  1  loader write (1) / read (0)
- l_addr_i  input  32  loader byte address
- l_wdata_i  input  32  loader write data
- l_gnt_o  output  1  loader request accepted this cycle
- l_rvalid_o  output  1  loader read data valid
- l_rdata_o  output  32  loader read data
- boot_done_i  input  1  loader finished writing the image
- running_o  output  1  high in RUN state
- err_o  output  1  sticky: an out-of-range access was granted
- mem_en_o, mem_we_o  output  1  memory access strobe / write enable
- mem_addr_o  output  32  memory byte address, bits [1:0] forced to 0
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, valid one cycle after mem_en_o

## Operation
- States: BOOT (reset state), RUN. BOOT -> RUN on any edge where boot_done_i=1; RUN never returns to BOOT except via reset.
- BOOT: f_gnt_o=0 always; loader requests granted whenever l_req_i=1.
- RUN: arbitration between f_req_i and l_req_i; at most one grant per cycle; single requester always granted.
- Contention policy: see Configuration.
- Granted access drives mem_en_o=1, mem_addr_o={addr[31:2],2'b00}, mem_we_o=l_we_i for loader, 0 for fetch.
- Range check: word index addr[31:2] >= DEPTH is out of range: still granted, mem_en_o=0, write dropped, read returns 32'h0, err_o set until reset.
- Read return: owner of the granted read registered; next cycle the matching *_rvalid_o=1 with *_rdata_o=mem_rdata_i (or 0 if out of range). Writes produce no rvalid.
- Non-owner rdata_o is 0; rvalid never asserted to both ports in one cycle.

## Timing
- Grants combinational from requests, state and priority pointer (same cycle).
- Read latency: exactly 1 cycle from grant to rvalid; back-to-back grants every cycle, full throughput.
- Reset values: state=BOOT, running_o=0, err_o=0, f_rvalid_o=0, l_rvalid_o=0, rdata outputs 0, priority pointer = fetch preferred; mem_en_o=0 while rst_i=0.
- Reset asserted with read outstanding: rvalid of that read is suppressed.
- boot_done_i and l_req_i in same cycle in BOOT: loader granted that cycle; fetch eligible from next cycle.
- A request not granted must be held by the requester; arbiter keeps no request queue.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin in RUN; on contention the port not granted last wins; pointer updates only on a contested grant.
- Undefined: fixed priority, fetch always wins over loader in RUN; loader can starve while fetch requests continuously.

## Test plan
- Reset then f_req_i=1, addr 0x0 held in BOOT -> f_gnt_o=0 for all BOOT cycles; running_o=0.
- BOOT: loader writes 0x2002000A to 0x4, pulse boot_done_i, fetch 0x4 -> f_gnt_o=1, next cycle f_rvalid_o=1, f_rdata_o=0x2002000A.
- RUN, both requesting continuously (RR_EN) -> grants alternate fetch, loader, fetch...; without macro -> f_gnt_o=1 every cycle, l_gnt_o=0.
- Fetch address 0x80 (DEPTH=32) -> granted, mem_en_o=0, next cycle f_rdata_o=0, err_o=1 and stays 1.
- Fetch 0x6 -> mem_addr_o=0x4.
- Grant read, assert rst_i=0 before next edge -> no rvalid; state BOOT, all outputs at reset values.
